// File: rtl/seg7_reader_if.sv
// Seven-segment receive bus: raw segment input and clear in, decoded digit,
// pulses, history and error count out.
interface seg7_reader_if #(
   parameter int NDIGITS   = 4,
   parameter int NBITS_ERR = 8
);
   logic [7:0]           seg_in;
   logic                 clear;
   logic [3:0]           digit_out;
   logic                 dp_out;
   logic                 digit_valid;
   logic                 invalid_pulse;
   logic                 stable;
   logic [4*NDIGITS-1:0] history;
   logic [NBITS_ERR-1:0] err_count;

   modport master (
      output seg_in, clear,
      input  digit_out, dp_out, digit_valid, invalid_pulse, stable, history, err_count
   );

   modport slave (
      input  seg_in, clear,
      output digit_out, dp_out, digit_valid, invalid_pulse, stable, history, err_count
   );
endinterface

// File: rtl/seg7_reader.sv
// Seven-segment bus receiver: synchronizes the segment pattern, waits for it to
// settle, decodes it to a hex digit and keeps a digit history plus error count.
module seg7_reader #(
   parameter int STABLE_CYCLES = 4,
   parameter int NDIGITS       = 4,
   parameter int NBITS_ERR     = 8
) (
   input  logic          clk_2,
   input  logic          reset_n,
   seg7_reader_if.slave  bus
);
   localparam int CW = $clog2(STABLE_CYCLES + 1);
   localparam int HW = 4 * NDIGITS;

   typedef enum logic [1:0] {BLANK, SETTLE, LOCKED} state_t;

   state_t               r_state, w_next;
   logic [7:0]           r_sync1, r_s;
   logic [6:0]           r_s_q;
   logic [CW-1:0]        r_cnt, w_cnt_nxt;
   logic [3:0]           r_digit;
   logic                 r_dp, r_dv, r_inv;
   logic [HW-1:0]        r_hist;
   logic [NBITS_ERR-1:0] r_err;

   logic [3:0]           w_code;
   logic                 w_legal, w_changed, w_blank, w_fire_ok, w_fire_bad;

   always_comb begin
      w_legal = 1'b1;
      w_code  = 4'h0;
      case (r_s[6:0])
         7'h3F: w_code = 4'h0;
         7'h06: w_code = 4'h1;
         7'h5B: w_code = 4'h2;
         7'h4F: w_code = 4'h3;
         7'h66: w_code = 4'h4;
         7'h6D: w_code = 4'h5;
         7'h7D: w_code = 4'h6;
         7'h07: w_code = 4'h7;
         7'h7F: w_code = 4'h8;
         7'h6F: w_code = 4'h9;
         7'h77: w_code = 4'hA;
         7'h7C: w_code = 4'hB;
         7'h39: w_code = 4'hC;
         7'h5E: w_code = 4'hD;
         7'h79: w_code = 4'hE;
         7'h71: w_code = 4'hF;
         default: w_legal = 1'b0;
      endcase
   end

   // dp (bit 7) is deliberately excluded from change detection
   assign w_changed = (r_s[6:0] != r_s_q);
   assign w_blank   = (r_s[6:0] == 7'h00);

   always_comb begin
      w_next     = r_state;
      w_cnt_nxt  = r_cnt;
      w_fire_ok  = 1'b0;
      w_fire_bad = 1'b0;
      if (bus.clear) begin
         w_cnt_nxt = '0;
         w_next    = w_blank ? BLANK : SETTLE;
      end else if (w_changed) begin
         w_cnt_nxt = '0;
         w_next    = w_blank ? BLANK : SETTLE;
      end else begin
         case (r_state)
            SETTLE: begin
               if (r_cnt == CW'(STABLE_CYCLES - 1)) begin
                  w_next     = LOCKED;
                  w_fire_ok  = w_legal;
                  w_fire_bad = ~w_legal;
               end else begin
                  w_cnt_nxt = r_cnt + CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_2 or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1 <= '0;
         r_s     <= '0;
         r_s_q   <= '0;
         r_state <= BLANK;
         r_cnt   <= '0;
      end else begin
         r_sync1 <= bus.seg_in;
         r_s     <= r_sync1;
         r_s_q   <= r_s[6:0];
         r_state <= w_next;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_ff @(posedge clk_2 or negedge reset_n) begin
      if (!reset_n) begin
         r_digit <= '0;
         r_dp    <= 1'b0;
         r_dv    <= 1'b0;
         r_inv   <= 1'b0;
         r_hist  <= '0;
         r_err   <= '0;
      end else begin
         r_dv  <= w_fire_ok;
         r_inv <= w_fire_bad;
         if (bus.clear) begin
            r_digit <= '0;
            r_dp    <= 1'b0;
            r_hist  <= '0;
            r_err   <= '0;
         end else if (w_fire_ok) begin
            r_digit <= w_code;
            r_dp    <= r_s[7];
            r_hist  <= (r_hist << 4) | HW'(w_code);
         end else if (w_fire_bad && (r_err != {NBITS_ERR{1'b1}})) begin
            r_err <= r_err + NBITS_ERR'(1);
         end
      end
   end

   assign bus.digit_out     = r_digit;
   assign bus.dp_out        = r_dp;
   assign bus.digit_valid   = r_dv;
   assign bus.invalid_pulse = r_inv;
   assign bus.stable        = (r_state == LOCKED);
   assign bus.history       = r_hist;
   assign bus.err_count     = r_err;
endmodule

// File: tb/tb_seg7_reader.sv
// Directed bench for seg7_reader: expected pulses queued at drive time and
// checked by a monitor on the falling edge.
module tb_seg7_reader;
   logic clk_2   = 1'b0;
   logic reset_n = 1'b0;

   seg7_reader_if #(.NDIGITS(4), .NBITS_ERR(8)) bus ();

   seg7_reader #(.STABLE_CYCLES(4), .NDIGITS(4), .NBITS_ERR(8)) dut (
      .clk_2   (clk_2),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk_2 = ~clk_2;

   typedef struct packed {
      logic        inv;
      logic [3:0]  d;
      logic        dp;
      logic [15:0] h;
      logic [7:0]  e;
   } exp_t;

   exp_t        sbq[$];
   int          total = 0;
   int          bad   = 0;
   int          cyc   = 0;
   int          npulse = 0;
   int          last_pulse_cyc = -1;
   logic [15:0] m_hist = '0;
   logic [7:0]  m_err  = '0;
   logic [3:0]  m_dig  = '0;
   logic        m_dp   = 1'b0;

   always @(posedge clk_2) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk_2) begin
      if (bus.digit_valid || bus.invalid_pulse) begin
         exp_t e;
         npulse++;
         last_pulse_cyc = cyc;
         chk("excl", {31'd0, bus.digit_valid & bus.invalid_pulse}, 0);
         chk("sb_nonempty", {31'd0, sbq.size() != 0}, 1);
         if (sbq.size() != 0) begin
            e = sbq.pop_front();
            chk("kind",  {31'd0, bus.invalid_pulse}, {31'd0, e.inv});
            chk("digit", {28'd0, bus.digit_out}, {28'd0, e.d});
            chk("dp",    {31'd0, bus.dp_out}, {31'd0, e.dp});
            chk("hist",  {16'd0, bus.history}, {16'd0, e.h});
            chk("err",   {24'd0, bus.err_count}, {24'd0, e.e});
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk_2);
         #1;
      end
   endtask

   task automatic drive(input logic [7:0] v, input int n);
      bus.seg_in = v;
      tick(n);
   endtask

   task automatic push_ok(input logic [3:0] d, input logic dp);
      m_hist = {m_hist[11:0], d};
      m_dig  = d;
      m_dp   = dp;
      sbq.push_back('{inv: 1'b0, d: d, dp: dp, h: m_hist, e: m_err});
   endtask

   task automatic push_bad();
      if (m_err != 8'hFF) m_err = m_err + 8'd1;
      sbq.push_back('{inv: 1'b1, d: m_dig, dp: m_dp, h: m_hist, e: m_err});
   endtask

   task automatic do_clear();
      bus.clear = 1'b1;
      tick(1);
      bus.clear = 1'b0;
      m_hist = '0; m_err = '0; m_dig = '0; m_dp = 1'b0;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_digit"},  {28'd0, bus.digit_out}, 0);
      chk({tag, "_dp"},     {31'd0, bus.dp_out}, 0);
      chk({tag, "_dv"},     {31'd0, bus.digit_valid}, 0);
      chk({tag, "_inv"},    {31'd0, bus.invalid_pulse}, 0);
      chk({tag, "_stable"}, {31'd0, bus.stable}, 0);
      chk({tag, "_hist"},   {16'd0, bus.history}, 0);
      chk({tag, "_err"},    {24'd0, bus.err_count}, 0);
   endtask

   initial begin
      int c0, np0;
      bus.seg_in = 8'h00;
      bus.clear  = 1'b0;

      // 1: reset and steady blank
      tick(3);
      chk_idle("rst");
      reset_n = 1'b1;
      drive(8'h00, 20);
      chk_idle("blank");
      chk("blank_pulses", npulse, 0);

      // 2: single glyph latency and no re-emission
      c0 = cyc;
      push_ok(4'h3, 1'b0);
      drive(8'h4F, 6);
      chk("lat_early_dv", {31'd0, bus.digit_valid}, 0);
      tick(1);
      chk("lat_dv",     {31'd0, bus.digit_valid}, 1);
      chk("lat_stable", {31'd0, bus.stable}, 1);
      chk("lat_digit",  {28'd0, bus.digit_out}, 3);
      chk("lat_hist",   {16'd0, bus.history}, 16'h0003);
      tick(50);
      chk("lat_cyc",   last_pulse_cyc, c0 + 7);
      chk("hold_once", npulse, 1);

      // 3: repeated glyph through blank, dp capture
      drive(8'h00, 10);
      do_clear();
      chk("clr_hist", {16'd0, bus.history}, 0);
      push_ok(4'h1, 1'b0); drive(8'h06, 10);
      drive(8'h00, 10);
      push_ok(4'h1, 1'b0); drive(8'h06, 10);
      push_ok(4'h6, 1'b1); drive(8'hFD, 10);
      push_ok(4'hA, 1'b0); drive(8'h77, 10);
      chk("seq_hist",  {16'd0, bus.history}, 16'h116A);
      chk("seq_digit", {28'd0, bus.digit_out}, 4'hA);
      chk("seq_dp",    {31'd0, bus.dp_out}, 0);

      // 4: short glitch is dropped
      drive(8'h00, 10);
      np0 = npulse;
      drive(8'h3F, 2);
      push_ok(4'h1, 1'b0);
      drive(8'h06, 10);
      chk("glitch_pulses", npulse - np0, 1);
      chk("glitch_hist", {16'd0, bus.history}, 16'h16A1);

      // 5: invalid patterns saturate the error counter
      drive(8'h00, 10);
      np0 = npulse;
      for (int i = 0; i < 300; i++) begin
         push_bad();
         drive(8'h55, 8);
         drive(8'h00, 4);
      end
      chk("inv_pulses", npulse - np0, 300);
      chk("inv_err",    {24'd0, bus.err_count}, 8'hFF);
      chk("inv_hist",   {16'd0, bus.history}, 16'h16A1);

      // 6: clear landing on the emit cycle defers the digit
      drive(8'h00, 10);
      do_clear();
      c0 = cyc;
      bus.seg_in = 8'h66;
      tick(6);
      bus.clear = 1'b1;
      tick(1);
      bus.clear = 1'b0;
      m_hist = '0; m_err = '0; m_dig = '0; m_dp = 1'b0;
      chk("clr_emit_dv",   {31'd0, bus.digit_valid}, 0);
      chk("clr_emit_hist", {16'd0, bus.history}, 0);
      chk("clr_emit_err",  {24'd0, bus.err_count}, 0);
      push_ok(4'h4, 1'b0);
      tick(4);
      chk("clr_re_dv", {31'd0, bus.digit_valid}, 1);
      tick(6);
      chk("clr_re_cyc", last_pulse_cyc, c0 + 11);

      // reset asserted mid-settle
      drive(8'h00, 10);
      np0 = npulse;
      bus.seg_in = 8'h6D;
      tick(4);
      #3;
      reset_n = 1'b0;
      #1;
      chk_idle("midrst");
      m_hist = '0; m_err = '0; m_dig = '0; m_dp = 1'b0;
      bus.seg_in = 8'h00;
      tick(2);
      reset_n = 1'b1;
      tick(10);
      chk("midrst_pulses", npulse - np0, 0);

      chk("sb_drained", sbq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
